// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential instruction fetch with a single outstanding request
// and a DEPTH-entry {pc, inst} prefetch queue feeding IF_ID.
module inst_fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    output logic                  fetch_req_o,
    output logic [ADDR_WIDTH-1:0] fetch_addr_o,
    input  logic                  memctrl_off_i,
    input  logic                  inst_ready_i,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  id_ready_i,
    output logic                  inst_valid_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] next_pc_o,
    output logic                  stall_req_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [PW:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] pc_mem_q [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
    logic                  accept, push, pop;

    assign fetch_req_o = !rst_in && state_q == IDLE && count_q < FULL && !jump_i;
    assign accept = fetch_req_o && memctrl_off_i;
    assign push = state_q == WAIT && inst_ready_i && !jump_i;
    assign pop = count_q != '0 && id_ready_i && !jump_i;

    always_comb begin
        state_d = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d = head_q;
        tail_d = tail_q;
        count_d = count_q;
        req_pc_d = accept ? fetch_pc_q : req_pc_q;
        if (jump_i) begin
            // a response still in flight must be swallowed before fetching again
            state_d = (state_q == IDLE || (state_q == WAIT && inst_ready_i)) ? IDLE : DISCARD;
            fetch_pc_d = jump_addr_i;
            head_d = '0;
            tail_d = '0;
            count_d = '0;
        end else begin
            state_d = (state_q == IDLE && accept) ? WAIT :
                      (state_q != IDLE && inst_ready_i) ? IDLE : state_q;
            fetch_pc_d = push ? req_pc_q + ADDR_WIDTH'(4) : fetch_pc_q;
            head_d = head_q + PW'(pop);
            tail_d = tail_q + PW'(push);
            count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q <= RESET_PC;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q <= req_pc_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            pc_mem_q[tail_q] <= req_pc_q;
            inst_mem_q[tail_q] <= inst_i;
        end
    end

    assign fetch_addr_o = fetch_pc_q;
    assign inst_valid_o = count_q != '0;
    assign stall_req_o = count_q == '0;
    assign inst_o = inst_mem_q[head_q];
    assign pc_o = pc_mem_q[head_q];
    assign next_pc_o = pc_o + ADDR_WIDTH'(4);
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed and random stimulus against a transaction-level
// model (expected queue contents, next fetch PC, outstanding/dropped request).
module tb_inst_fetch_queue;
    logic        clk_in = 0;
    logic        rst_in = 1;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        memctrl_off_i = 0;
    logic        inst_ready_i = 0;
    logic [31:0] inst_i = 0;
    logic        jump_i = 0;
    logic [31:0] jump_addr_i = 0;
    logic        id_ready_i = 0;
    logic        inst_valid_o;
    logic [31:0] inst_o, pc_o, next_pc_o;
    logic        stall_req_o;

    inst_fetch_queue #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .fetch_req_o(fetch_req_o), .fetch_addr_o(fetch_addr_o),
        .memctrl_off_i(memctrl_off_i), .inst_ready_i(inst_ready_i), .inst_i(inst_i),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i), .id_ready_i(id_ready_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o), .next_pc_o(next_pc_o),
        .stall_req_o(stall_req_o)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
    ent_t        m_q[$];
    logic [31:0] m_fetch, m_req;
    bit          m_busy, m_drop;
    bit          pend;
    int          wait_c;
    int          checks = 0, failures = 0;
    bit          jmp = 0, idr = 0, moff = 1, data_k = 0;
    logic [31:0] jaddr = 0;
    int          lmin = 1, lmax = 1;
    int          k = 0;

    task automatic model_reset();
        m_q.delete();
        m_fetch = 32'h0;
        m_busy = 0;
        m_drop = 0;
        pend = 0;
    endtask

    // one clock: drive inputs, check request side, advance model, check queue head
    task automatic cycle();
        bit          rdy, exp_req;
        logic [31:0] d;
        rdy = 0;
        if (pend) begin
            if (wait_c == 0) begin rdy = 1; pend = 0; end
            else wait_c--;
        end
        d = data_k ? 32'hA0 + k : $urandom;
        if (rdy) k++;
        inst_ready_i = rdy;
        inst_i = rdy ? d : $urandom;
        jump_i = jmp;
        jump_addr_i = jaddr;
        id_ready_i = idr;
        memctrl_off_i = moff;
        #1;
        exp_req = !m_busy && m_q.size() < 4 && !jmp;
        checks++;
        if (fetch_req_o !== exp_req) begin
            failures++;
            $display("FAIL fetch_req got=%0b exp=%0b t=%0t", fetch_req_o, exp_req, $time);
        end
        checks++;
        if (fetch_addr_o !== m_fetch) begin
            failures++;
            $display("FAIL fetch_addr got=%h exp=%h t=%0t", fetch_addr_o, m_fetch, $time);
        end
        if (jmp) begin
            m_q.delete();
            m_fetch = jaddr;
            if (m_busy) begin
                if (rdy) m_busy = 0;
                else m_drop = 1;
            end
        end else begin
            if (m_q.size() > 0 && idr) void'(m_q.pop_front());
            if (rdy && m_busy) begin
                if (!m_drop) begin
                    m_q.push_back('{pc: m_req, inst: d});
                    m_fetch = m_req + 32'd4;
                end
                m_busy = 0;
                m_drop = 0;
            end
        end
        if (exp_req && moff) begin
            m_busy = 1;
            m_drop = 0;
            m_req = m_fetch;
            pend = 1;
            wait_c = $urandom_range(lmin, lmax) - 1;
        end
        @(posedge clk_in);
        #1;
        checks++;
        if (inst_valid_o !== (m_q.size() != 0) || stall_req_o !== (m_q.size() == 0)) begin
            failures++;
            $display("FAIL valid_stall got=%0b%0b exp_size=%0d t=%0t", inst_valid_o, stall_req_o, m_q.size(), $time);
        end
        if (m_q.size() != 0) begin
            checks++;
            if (pc_o !== m_q[0].pc || inst_o !== m_q[0].inst || next_pc_o !== m_q[0].pc + 32'd4) begin
                failures++;
                $display("FAIL head got pc=%h inst=%h npc=%h exp pc=%h inst=%h t=%0t",
                         pc_o, inst_o, next_pc_o, m_q[0].pc, m_q[0].inst, $time);
            end
        end
    endtask

    task automatic timeout(input string name);
        failures++;
        $display("FAIL %s timeout waiting for condition t=%0t", name, $time);
    endtask

    task automatic test_reset();
        rst_in = 1;
        memctrl_off_i = 1;
        #2;
        checks++;
        if (fetch_req_o !== 0 || inst_valid_o !== 0 || stall_req_o !== 1 || fetch_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset got req=%0b valid=%0b stall=%0b addr=%h exp 0 0 1 0", fetch_req_o, inst_valid_o, stall_req_o, fetch_addr_o);
        end
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (fetch_req_o !== 0 || inst_valid_o !== 0) begin
            failures++;
            $display("FAIL reset_hold got req=%0b valid=%0b exp 0 0", fetch_req_o, inst_valid_o);
        end
        rst_in = 0;
        model_reset();
    endtask

    task automatic test_fill();
        int n = 0;
        lmin = 1; lmax = 1; moff = 1; idr = 0; jmp = 0; data_k = 1; k = 0;
        while (m_q.size() < 4 && n < 30) begin cycle(); n++; end
        if (m_q.size() < 4) timeout("fill");
        cycle();
        checks++;
        if (fetch_req_o !== 0 || pc_o !== 32'h0 || inst_o !== 32'hA0 || fetch_addr_o !== 32'h10) begin
            failures++;
            $display("FAIL fill_full got req=%0b pc=%h inst=%h addr=%h exp 0 0 a0 10", fetch_req_o, pc_o, inst_o, fetch_addr_o);
        end
    endtask

    task automatic test_drain();
        idr = 1;
        repeat (12) cycle();
        idr = 0;
        data_k = 0;
    endtask

    task automatic test_jump_wait();
        int n = 0;
        lmin = 3; lmax = 3; moff = 1; idr = 0;
        while (!(m_busy && !m_drop && pend && wait_c == 2) && n < 30) begin cycle(); n++; end
        if (!m_busy) timeout("jump_wait_accept");
        jmp = 1; jaddr = 32'h100;
        cycle();
        jmp = 0;
        checks++;
        if (inst_valid_o !== 0 || stall_req_o !== 1) begin
            failures++;
            $display("FAIL jump_flush got valid=%0b stall=%0b exp 0 1", inst_valid_o, stall_req_o);
        end
        n = 0;
        lmin = 1; lmax = 1;
        while (m_q.size() == 0 && n < 30) begin cycle(); n++; end
        checks++;
        if (pc_o !== 32'h100 || inst_valid_o !== 1) begin
            failures++;
            $display("FAIL jump_first_pc got pc=%h valid=%0b exp 100 1", pc_o, inst_valid_o);
        end
    endtask

    task automatic test_jump_coincident();
        int n = 0;
        moff = 0; idr = 0; lmin = 1; lmax = 1;
        while (m_busy && n < 30) begin cycle(); n++; end
        if (m_busy) timeout("coinc_idle");
        jmp = 1; jaddr = 32'h200;
        cycle();
        jmp = 0; moff = 1; n = 0;
        while (!(m_q.size() == 2 && pend && wait_c == 0) && n < 30) begin cycle(); n++; end
        if (m_q.size() != 2) timeout("coinc_fill");
        jmp = 1; jaddr = 32'h300; idr = 1;
        cycle();
        jmp = 0; idr = 0;
        jump_i = 0;
        #1;
        checks++;
        if (inst_valid_o !== 0 || fetch_req_o !== 1 || fetch_addr_o !== 32'h300) begin
            failures++;
            $display("FAIL jump_coinc got valid=%0b req=%0b addr=%h exp 0 1 300", inst_valid_o, fetch_req_o, fetch_addr_o);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        moff = 1; idr = 0; lmin = 1; lmax = 1;
        while (!(m_q.size() == 3 && pend && wait_c == 0) && n < 30) begin cycle(); n++; end
        if (m_q.size() != 3) timeout("b2b_fill");
        idr = 1;
        cycle();
        idr = 0;
        jump_i = 0;
        memctrl_off_i = 0;
        #1;
        checks++;
        if (inst_valid_o !== 1 || fetch_req_o !== 1) begin
            failures++;
            $display("FAIL b2b_count3 got valid=%0b req=%0b exp 1 1", inst_valid_o, fetch_req_o);
        end
        idr = 1; lmin = 1; lmax = 2;
        repeat (40) cycle();
    endtask

    task automatic test_addr_wrap();
        int n = 0;
        moff = 0; idr = 0; lmin = 1; lmax = 1;
        while (m_busy && n < 30) begin cycle(); n++; end
        if (m_busy) timeout("wrap_idle");
        jmp = 1; jaddr = 32'hFFFF_FFFC;
        cycle();
        jmp = 0; moff = 1; n = 0;
        while (m_q.size() == 0 && n < 30) begin cycle(); n++; end
        checks++;
        if (pc_o !== 32'hFFFF_FFFC || next_pc_o !== 32'h0 || fetch_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL addr_wrap got pc=%h npc=%h addr=%h exp fffffffc 0 0", pc_o, next_pc_o, fetch_addr_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n = 0;
        moff = 1; idr = 0; lmin = 3; lmax = 3;
        while (!m_busy && n < 30) begin cycle(); n++; end
        if (!m_busy) timeout("rst_wait");
        rst_in = 1;
        #1;
        checks++;
        if (fetch_req_o !== 0 || inst_valid_o !== 0 || stall_req_o !== 1 || fetch_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_wait got req=%0b valid=%0b stall=%0b addr=%h exp 0 0 1 0", fetch_req_o, inst_valid_o, stall_req_o, fetch_addr_o);
        end
        @(posedge clk_in);
        #1;
        rst_in = 0;
        model_reset();
        lmin = 1; lmax = 2;
        repeat (6) cycle();
    endtask

    task automatic test_random();
        lmin = 1; lmax = 4;
        for (int i = 0; i < 3000; i++) begin
            idr = $urandom_range(0, 2) != 0;
            moff = $urandom_range(0, 3) != 0;
            jmp = $urandom_range(0, 19) == 0 && !(m_drop && pend && wait_c == 0);
            jaddr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            cycle();
        end
        jmp = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_jump_wait();
        test_jump_coincident();
        test_back_to_back();
        test_addr_wrap();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction-fetch stage with a prefetch queue. It generates sequential fetch addresses, issues single-outstanding word requests to the memory controller, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. The FIFO feeds IF_ID under a valid/ready handshake. A redirect from EX flushes the queue and discards any in-flight response. It sits between the PC/branch logic and IF_ID and replaces the combinational fetch stage.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of PCs and fetch addresses
- INST_WIDTH, 32, instruction word width
- DEPTH, 4, queue entries; power of two, minimum 2
- RESET_PC, 0, first fetch address after reset

Ports:
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  asynchronous, active-high reset
- fetch_req_o  output  1  request a word at fetch_addr_o
- fetch_addr_o  output  ADDR_WIDTH  fetch address (current fetch PC)
- memctrl_off_i  input  1  memory controller idle; a request is accepted in any cycle where fetch_req_o and memctrl_off_i are both high
- inst_ready_i  input  1  one-cycle pulse: inst_i holds the requested word
- inst_i  input  INST_WIDTH  returned instruction
- jump_i  input  1  redirect: flush and restart at jump_addr_i
- jump_addr_i  input  ADDR_WIDTH  redirect target
- id_ready_i  input  1  IF_ID accepts the head entry this cycle
- inst_valid_o  output  1  queue non-empty; head entry valid
- inst_o  output  INST_WIDTH  head instruction
- pc_o  output  ADDR_WIDTH  PC of head instruction
- next_pc_o  output  ADDR_WIDTH  pc_o + 4, modulo 2^ADDR_WIDTH
- stall_req_o  output  1  high when queue empty

## Operation
- State: fetch_pc, FSM {IDLE, WAIT, DISCARD}, req_pc, storage of DEPTH × {pc, inst}, head/tail pointers (log2 DEPTH bits, wrap naturally), count (log2 DEPTH + 1 bits).
- fetch_req_o = (state==IDLE) && (count < DEPTH) && !jump_i. fetch_addr_o = fetch_pc.
- IDLE: if a request is accepted, latch req_pc = fetch_pc and go to WAIT.
- WAIT: on inst_ready_i without jump_i, push {req_pc, inst_i} at tail, set fetch_pc = req_pc + 4, and go to IDLE.
- Redirect (jump_i high), highest priority:
  - count, head and tail go to 0; fetch_pc = jump_addr_i.
  - In IDLE, or in WAIT with inst_ready_i in the same cycle: any response is dropped and the next state is IDLE.
  - In WAIT without inst_ready_i: next state is DISCARD.
  - In DISCARD: stay in DISCARD.
  - A pop in the same cycle is ignored, and the flush wins.
- DISCARD: on inst_ready_i, drop the data and go to IDLE. No request is issued while in DISCARD.
- Pop: inst_valid_o && id_ready_i && !jump_i advances head. Push and pop in the same cycle leave count unchanged.
- Overflow is impossible by construction. A request is issued only when count < DEPTH, with at most one outstanding, so a push never finds the queue full.
- inst_valid_o = (count != 0). stall_req_o = (count == 0). inst_o and pc_o come from the head entry. All outputs are driven from registers except fetch_req_o, which also depends on jump_i.
- inst_ready_i outside WAIT/DISCARD is a protocol error and is ignored.

## Timing
- Reset values: state IDLE, fetch_pc = RESET_PC, count/head/tail = 0, inst_valid_o = 0, stall_req_o = 1. While rst_in is high, fetch_req_o = 0.
- Accept at edge N: state is WAIT from N+1.
- Response at edge M: the entry is visible on inst_valid_o/inst_o/pc_o from M+1. The next request can be issued in cycle M+1, so a 1-cycle memctrl gives one instruction per 2 cycles.
- Jump at edge J: the queue is empty and stall_req_o = 1 from J+1.
  - The first request to jump_addr_i is at J+1 if no response is pending.
  - Otherwise it follows the cycle after the discarded inst_ready_i.
- Reset asserted mid-WAIT: everything returns to reset values immediately. The pending response is not tracked and is ignored (state IDLE).

## Test plan
- Reset, RESET_PC=0x0, memctrl returns word 0xA0+k one cycle after each accept, id_ready_i=0 -> requests at 0x0,0x4,0x8,0xC; fetch_req_o drops once count=4; head pc_o=0x0, inst_o=0xA0.
- Then hold id_ready_i=1 -> entries pop in order with pc_o 0x0,0x4,…; next_pc_o=pc_o+4; fetching resumes at 0x10.
- Jump to 0x100 while in WAIT, response arrives 2 cycles later -> response dropped, count=0 next cycle; next request address is 0x100; the first pushed pc is 0x100.
- Jump coincident with inst_ready_i and id_ready_i on a count=2 queue -> nothing pushed or popped, count=0, state IDLE, request to jump target in the following cycle.
- Push and pop in the same cycle with count=3 -> count stays 3; ordering preserved across pointer wrap after more than 8 instructions.
- fetch_pc=0xFFFFFFFC, ADDR_WIDTH=32 -> next_pc_o=0x0, next fetch address 0x0.
